// File: rtl/serial_slt_unit_pkg.sv
// Shared definitions for the serial set-on-less-than engine: state encoding,
// default geometry and the step-counter width helper.
package serial_slt_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_STEP  = 1;

  // A single-step engine still needs a one-bit counter to exist.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_slt_unit_sub_slice.sv
// Combinational STEP-bit subtract slice: a + ~b + cin, exposing the carry into
// the top bit so the parent can detect signed overflow.
module serial_sub_slice #(
  parameter int STEP = 1
) (
  input  logic [STEP-1:0] a_bits,
  input  logic [STEP-1:0] b_bits,
  input  logic            cin,
  output logic [STEP-1:0] sum,
  output logic            cout,
  output logic            cin_msb
);

  logic [STEP-1:0] nb;
  logic [STEP:0]   carry;

  assign nb = ~b_bits;

  // NOTE: every signal written here gets a value before any branch or loop,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < STEP; i++) begin
      sum[i]       = a_bits[i] ^ nb[i] ^ carry[i];
      carry[i + 1] = (a_bits[i] & nb[i]) | (a_bits[i] & carry[i]) | (nb[i] & carry[i]);
    end
  end

  assign cout    = carry[STEP];
  assign cin_msb = carry[STEP-1];

endmodule

// File: rtl/serial_slt_unit.sv
// Multi-cycle slt/sltu engine: subtracts b from a STEP bits per cycle, LSB
// first, and reports the less-than flag plus the full difference.
module serial_slt_unit
  import serial_slt_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STEP  = DEFAULT_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_op,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             lt,
  output logic [WIDTH-1:0] diff
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = cnt_width(N);

  if ((STEP < 1) || ((WIDTH % STEP) != 0)) begin : g_bad_step
    $error("serial_slt_unit: STEP must divide WIDTH");
  end

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sh, b_sh, diff_next;
  logic [CW-1:0]    cnt;
  logic             carry, signed_q;
  logic [STEP-1:0]  sum;
  logic             cout, cin_msb, last_step, lt_next;

  serial_sub_slice #(.STEP(STEP)) u_slice (
    .a_bits  (a_sh[STEP-1:0]),
    .b_bits  (b_sh[STEP-1:0]),
    .cin     (carry),
    .sum     (sum),
    .cout    (cout),
    .cin_msb (cin_msb)
  );

  // New sum bits enter at the top so diff is aligned after the last step.
  if (STEP == WIDTH) begin : g_full
    assign diff_next = sum;
  end else begin : g_part
    assign diff_next = {sum, diff[WIDTH-1:STEP]};
  end

  assign last_step = (cnt == CW'(N - 1));
  assign lt_next   = signed_q ? (sum[STEP-1] ^ cin_msb ^ cout) : ~cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start)        next_state = RUN;
      RUN:     if (last_step)    next_state = DONE;
      DONE:    if (result_ready) next_state = IDLE;
      default:                   next_state = IDLE;
    endcase
  end

  // NOTE: the operand shift registers are plain flops, not a memory, so they
  // take the reset like every other piece of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b1;
      cnt      <= '0;
      signed_q <= 1'b0;
      diff     <= '0;
      lt       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees the
      // pre-edge values of the others, regardless of statement order.
      unique case (state)
        IDLE: if (start) begin
          a_sh     <= a;
          b_sh     <= b;
          signed_q <= signed_op;
          carry    <= 1'b1;
          cnt      <= '0;
        end
        RUN: begin
          a_sh  <= a_sh >> STEP;
          b_sh  <= b_sh >> STEP;
          carry <= cout;
          cnt   <= cnt + CW'(1);
          diff  <= diff_next;
          if (last_step) lt <= lt_next;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);

endmodule
